// File: rtl/dds_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dds_pkg
// Brief    : Shared types and default widths for the DDS sweep sequencer.
//            Optional feature macro used by dds_sweep_ctrl: DDS_SWEEP_BIDIR_EN
// Revision : 1.0  initial release
// ============================================================================
package dds_pkg;

  localparam int DDS_N = 8;
  localparam int DDS_D = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } dds_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dds_dir_e;

endpackage
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dds_dwell_timer
// Brief    : Loadable down-counter. expire_o flags the last cycle of a dwell;
//            on that cycle the count reloads from reload_val_i so the next
//            value gets a full dwell without any idle gap.
// Revision : 1.0  initial release
// ============================================================================
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int D = DDS_D
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [D-1:0] load_val_i,
  input  logic         en_i,
  input  logic [D-1:0] reload_val_i,
  output logic         expire_o
);

  logic [D-1:0] cnt_q;
  logic [D-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == '0);

  // Next count: explicit load wins, otherwise count down and wrap to reload value
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? reload_val_i : (cnt_q - D'(1));
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Brief    : Frequency-sweep sequencer for the DDS phase accumulator. Steps
//            the tuning word from f_start towards f_stop, holding each value
//            for cfg_dwell+1 cycles, with single-shot or looping operation.
//            Optional macro DDS_SWEEP_BIDIR_EN: triangle (up then down) sweep.
// Revision : 1.0  initial release
// ============================================================================
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int N = DDS_N,
  parameter int D = DDS_D
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N:0]   cfg_f_start,
  input  logic [N:0]   cfg_f_stop,
  input  logic [N:0]   cfg_f_step,
  input  logic [D-1:0] cfg_dwell,
  input  logic [N:0]   cfg_phase,
  input  logic         cfg_loop,
  output logic [N:0]   freq_out,
  output logic [N:0]   phase_out,
  output logic         acc_clear,
  output logic         busy,
  output logic         done,
  output logic         sweep_wrap
);

  // State and output registers
  dds_state_e state_q, state_d;
  logic [N:0] freq_q, freq_d;
  logic [N:0] phase_q, phase_d;
  logic       clear_q, clear_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;

  // Configuration captured when a sweep is accepted
  logic [N:0]   fstart_q, fstart_d;
  logic [N:0]   fstop_q, fstop_d;
  logic [N:0]   fstep_q, fstep_d;
  logic [D-1:0] dwell_q, dwell_d;
  logic         loop_q, loop_d;

  // Dwell timer handshake
  logic tmr_load;
  logic tmr_en;
  logic tmr_expire;

  // Step arithmetic, one bit wider so the carry is visible
  logic [N+1:0] up_sum;
  logic         up_end;
  logic         end_sweep;

  assign up_sum = {1'b0, freq_q} + {1'b0, fstep_q};
  assign up_end = up_sum[N+1] || (up_sum[N:0] > fstop_q);

`ifdef DDS_SWEEP_BIDIR_EN
  dds_dir_e     dir_q, dir_d;
  logic [N+1:0] dn_diff;
  logic         dn_end;

  assign dn_diff = {1'b0, freq_q} - {1'b0, fstep_q};
  assign dn_end  = dn_diff[N+1] || (dn_diff[N:0] < fstart_q);
`endif

  dds_dwell_timer #(
    .D (D)
  ) u_dwell_timer (
    .clk_i        (clock),
    .rst_i        (reset),
    .load_i       (tmr_load),
    .load_val_i   (cfg_dwell),
    .en_i         (tmr_en),
    .reload_val_i (dwell_q),
    .expire_o     (tmr_expire)
  );

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    phase_d   = phase_q;
    clear_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    fstart_d  = fstart_q;
    fstop_d   = fstop_q;
    fstep_d   = fstep_q;
    dwell_d   = dwell_q;
    loop_d    = loop_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    end_sweep = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    dir_d     = dir_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // abort alongside start keeps the block idle
        if (start && !abort) begin
          state_d  = ST_LOAD;
          fstart_d = cfg_f_start;
          fstop_d  = cfg_f_stop;
          fstep_d  = cfg_f_step;
          dwell_d  = cfg_dwell;
          loop_d   = cfg_loop;
          freq_d   = cfg_f_start;
          phase_d  = cfg_phase;
          clear_d  = 1'b1;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_d    = DIR_UP;
`endif
        end
      end

      ST_LOAD, ST_DWELL: begin
        if (abort) begin
          state_d = ST_IDLE;
          freq_d  = '0;
          busy_d  = 1'b0;
        end else begin
          // LOAD is the first hold cycle of f_start, so the timer runs here too
          state_d = ST_DWELL;
          tmr_en  = 1'b1;
          if (tmr_expire) begin
`ifdef DDS_SWEEP_BIDIR_EN
            if (dir_q == DIR_UP) begin
              if (!up_end) begin
                freq_d = up_sum[N:0];
              end else if (!dn_end) begin
                dir_d  = DIR_DOWN;
                freq_d = dn_diff[N:0];
              end else begin
                end_sweep = 1'b1;
              end
            end else begin
              if (!dn_end) begin
                freq_d = dn_diff[N:0];
              end else begin
                end_sweep = 1'b1;
              end
            end
`else
            if (!up_end) begin
              freq_d = up_sum[N:0];
            end else begin
              end_sweep = 1'b1;
            end
`endif
            if (end_sweep) begin
              if (loop_q) begin
                // Restart without clearing the accumulator: phase stays continuous
                freq_d = fstart_q;
                wrap_d = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
                dir_d  = DIR_UP;
`endif
              end else begin
                // Last value stays on freq_out after completion
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, output and configuration registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      freq_q   <= '0;
      phase_q  <= '0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      phase_q  <= phase_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
    end
  end

`ifdef DDS_SWEEP_BIDIR_EN
  // Sweep direction register for the triangle sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign freq_out   = freq_q;
  assign phase_out  = phase_q;
  assign acc_clear  = clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sweep_wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Brief    : Directed self-checking bench for dds_sweep_ctrl.
//            Honours DDS_SWEEP_BIDIR_EN for the direction-dependent vector.
// Revision : 1.0  initial release
// ============================================================================
module tb_dds_sweep_ctrl;

  localparam int N = 8;
  localparam int D = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N:0]   cfg_f_start = '0;
  logic [N:0]   cfg_f_stop  = '0;
  logic [N:0]   cfg_f_step  = '0;
  logic [D-1:0] cfg_dwell   = '0;
  logic [N:0]   cfg_phase   = '0;
  logic         cfg_loop    = 1'b0;
  logic [N:0]   freq_out;
  logic [N:0]   phase_out;
  logic         acc_clear;
  logic         busy;
  logic         done;
  logic         sweep_wrap;

  int vecs = 0;
  int errs = 0;

  int seq[12] = '{10, 10, 10, 20, 20, 20, 30, 30, 30, 40, 40, 40};

  always #5 clock = ~clock;

  dds_sweep_ctrl #(
    .N (N),
    .D (D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_f_step  (cfg_f_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_phase   (cfg_phase),
    .cfg_loop    (cfg_loop),
    .freq_out    (freq_out),
    .phase_out   (phase_out),
    .acc_clear   (acc_clear),
    .busy        (busy),
    .done        (done),
    .sweep_wrap  (sweep_wrap)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int f, input int b, input int c,
                         input int d, input int w);
    chk({tag, "_freq"},  32'(freq_out),   f);
    chk({tag, "_busy"},  32'(busy),       b);
    chk({tag, "_clear"}, 32'(acc_clear),  c);
    chk({tag, "_done"},  32'(done),       d);
    chk({tag, "_wrap"},  32'(sweep_wrap), w);
  endtask

  task automatic set_cfg(input int fs, input int fe, input int st, input int dw, input int lp);
    cfg_f_start = fs[N:0];
    cfg_f_stop  = fe[N:0];
    cfg_f_step  = st[N:0];
    cfg_dwell   = dw[D-1:0];
    cfg_loop    = lp[0];
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held, before any clock edge
    #2;
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst_phase", 32'(phase_out), 0);
    #10;
    reset = 1'b0;

    // Single-shot sweep 10..40 step 10, dwell 2
    set_cfg(10, 40, 10, 2, 0);
    cfg_phase = 9'd77;
    launch();
    for (int i = 0; i < 12; i++) begin
      chk_out("ss", seq[i], 1, (i == 0) ? 1 : 0, 0, 0);
      if (i == 1) chk("ss_phase", 32'(phase_out), 77);
      tick();
    end
    chk_out("ss_end", 40, 0, 0, 1, 0);
    tick();
    chk_out("ss_after", 40, 0, 0, 0, 0);

    // Looping sweep, two full periods, then abort out
    set_cfg(10, 40, 10, 2, 1);
    launch();
    for (int i = 0; i < 25; i++) begin
      chk_out("loop", seq[i % 12], 1, (i == 0) ? 1 : 0, 0,
              (i == 12 || i == 24) ? 1 : 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("loop_abort", 0, 0, 0, 0, 0);

    // Carry past the top of the word ends the sweep
    set_cfg(500, 511, 10, 0, 0);
    launch();
    chk_out("ovf0", 500, 1, 1, 0, 0);
    tick();
    chk_out("ovf1", 510, 1, 0, 0, 0);
    tick();
    chk_out("ovf_end", 510, 0, 0, 1, 0);

    // Abort during the 20 dwell, then start+abort together, then restart
    set_cfg(10, 40, 10, 2, 0);
    launch();
    for (int i = 0; i < 5; i++) begin
      chk_out("ab_pre", seq[i], 1, (i == 0) ? 1 : 0, 0, 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("ab_now", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("ab_idle", 0, 0, 0, 0, 0);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_out("ab_both", 0, 0, 0, 0, 0);
    launch();
    for (int i = 0; i < 12; i++) begin
      chk_out("ab_re", seq[i], 1, (i == 0) ? 1 : 0, 0, 0);
      tick();
    end
    chk_out("ab_re_end", 40, 0, 0, 1, 0);

    // Start re-pulsed and config changed mid-sweep: sequence unaffected
    set_cfg(10, 40, 10, 2, 0);
    cfg_phase = 9'd77;
    launch();
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        start       = 1'b1;
        cfg_f_stop  = 9'd20;
        cfg_f_start = 9'd100;
        cfg_phase   = 9'd5;
      end
      if (i == 4) start = 1'b0;
      chk_out("cfg", seq[i], 1, (i == 0) ? 1 : 0, 0, 0);
      tick();
    end
    chk_out("cfg_end", 40, 0, 0, 1, 0);
    chk("cfg_phase", 32'(phase_out), 77);

    // Zero step holds f_start until abort
    set_cfg(10, 40, 0, 1, 0);
    launch();
    for (int i = 0; i < 8; i++) begin
      chk_out("step0", 10, 1, (i == 0) ? 1 : 0, 0, 0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("step0_abort", 0, 0, 0, 0, 0);

    // f_start above f_stop: one dwell of f_start then done
    set_cfg(50, 40, 10, 1, 0);
    launch();
    chk_out("inv0", 50, 1, 1, 0, 0);
    tick();
    chk_out("inv1", 50, 1, 0, 0, 0);
    tick();
    chk_out("inv_end", 50, 0, 0, 1, 0);

    // Direction-dependent sweep 10..30 step 10, dwell 0
    set_cfg(10, 30, 10, 0, 0);
    launch();
    chk_out("dir0", 10, 1, 1, 0, 0);
    tick();
    chk_out("dir1", 20, 1, 0, 0, 0);
    tick();
    chk_out("dir2", 30, 1, 0, 0, 0);
    tick();
`ifdef DDS_SWEEP_BIDIR_EN
    chk_out("dir3", 20, 1, 0, 0, 0);
    tick();
    chk_out("dir4", 10, 1, 0, 0, 0);
    tick();
    chk_out("dir_end", 10, 0, 0, 1, 0);
`else
    chk_out("dir_end", 30, 0, 0, 1, 0);
`endif

    // Asynchronous reset in the middle of a sweep
    set_cfg(10, 40, 10, 2, 0);
    cfg_phase = 9'd33;
    launch();
    tick();
    tick();
    chk("ar_pre", 32'(freq_out), 10);
    reset = 1'b1;
    #1;
    chk_out("ar", 0, 0, 0, 0, 0);
    chk("ar_phase", 32'(phase_out), 0);
    #1;
    reset = 1'b0;
    tick();
    chk_out("ar_idle", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase accumulator. Steps a frequency tuning word from a start value to a stop value in fixed increments. Each value is held for a programmable number of cycles. The block drives the accumulator's `freq_in` and `phase_in` and issues a clear pulse at sweep start. It sits between the register/control layer and `phase_accumulator`, and supports single-shot or looping sweeps.

## Interface
- `N`, default 8: tuning/phase word is `N+1` bits, matching `phase_accumulator`.
- `D`, default 16: dwell counter width.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  terminate sweep immediately.
- `cfg_f_start`  in  N+1  first tuning word.
- `cfg_f_stop`  in  N+1  last allowed tuning word (inclusive).
- `cfg_f_step`  in  N+1  increment per step.
- `cfg_dwell`  in  D  each value is held for `cfg_dwell+1` cycles.
- `cfg_phase`  in  N+1  phase offset, forwarded to `phase_out`.
- `cfg_loop`  in  1  1 = restart sweep at end; 0 = single shot.
- `freq_out`  out  N+1  connects to accumulator `freq_in`.
- `phase_out`  out  N+1  connects to accumulator `phase_in`.
- `acc_clear`  out  1  one-cycle clear for the accumulator; OR it into the accumulator reset.
- `busy`  out  1  high from LOAD until return to IDLE.
- `done`  out  1  one-cycle pulse at natural sweep completion.
- `sweep_wrap`  out  1  one-cycle pulse when a looping sweep restarts.

## Operation
- All outputs are registered.
- Reset values: `freq_out`=0, `phase_out`=0, `acc_clear`=0, `busy`=0, `done`=0, `sweep_wrap`=0, state IDLE.
- States and transitions:
  - IDLE: on `start`, go to LOAD.
  - LOAD: lasts one cycle, then DWELL.
  - DWELL: loops in place until the end of the sweep or `abort`.
- Config latching: all `cfg_*` inputs are captured on the edge that accepts `start`. Later changes to `cfg_*` have no effect until the next sweep.
- LOAD outputs: `freq_out`=f_start, `phase_out`=cfg_phase, `acc_clear`=1, `busy`=1.
- DWELL hold: each `freq_out` value is presented for exactly `cfg_dwell+1` cycles. The LOAD cycle counts as the first cycle of f_start.
- Next-value arithmetic: next = freq + step, computed `N+2` bits wide. The sweep ends if the carry is set or next > f_stop.
- End of sweep:
  - `cfg_loop`=0: pulse `done`, clear `busy`, go to IDLE. `freq_out` holds the last value.
  - `cfg_loop`=1: `freq_out` reloads f_start and `sweep_wrap` pulses. No `acc_clear`; phase stays continuous.
- Boundary cases:
  - step=0 with f_start ≤ f_stop: holds f_start until `abort`.
  - f_start > f_stop: f_start is presented for one dwell, then the sweep ends.
- `abort`, in any non-IDLE state: go to IDLE on the next edge with `freq_out`=0 and `busy`=0. No `done` pulse.
- `abort` has priority over all other transitions. If `start` and `abort` are both high in IDLE, the block stays in IDLE.
- `start` while `busy` is ignored.

## Timing
- Start latency: `start` high at edge k (IDLE) → after edge k, state is LOAD with `busy`=1, `acc_clear`=1, `freq_out`=f_start.
- After edge k+1, `acc_clear` is 0.
- Single-shot run of M values holds `busy` for M·(cfg_dwell+1) cycles.
- `done` is asserted in the cycle after the last value's final dwell cycle, coincident with `busy` falling.
- `done` and `sweep_wrap` are never asserted together.
- Reset asserted mid-sweep forces all outputs to their reset values asynchronously.

## Configuration
- Macro `DDS_SWEEP_BIDIR_EN`.
- Defined (triangle sweep):
  - When next-up > f_stop (or carry), the direction flips to down and next = freq − step.
  - In the down direction, the sweep ends when next-down < f_start or the subtraction borrows.
  - Loop reload goes to f_start with direction up.
- Undefined (sawtooth): up-count only, as described in Operation.

## Structure
- Package `dds_pkg`:
  - state enum (IDLE, LOAD, DWELL);
  - direction type;
  - default widths `DDS_N`=8 and `DDS_D`=16.
- Sub-module `dds_dwell_timer`:
  - loadable down-counter of width D;
  - `expire` pulse when the count reaches 0, reloaded from `cfg_dwell`.
- FSM and step arithmetic stay in the top level.

## Test plan
- Single-shot sweep: f_start=10, f_stop=40, step=10, dwell=2, loop=0.
  - `freq_out` = 10,10,10,20,20,20,30,30,30,40,40,40.
  - `done` pulses once; `busy` is high for 12 cycles; `acc_clear` is high only in the first cycle.
- Loop mode, same config with loop=1: after the third 40, `freq_out`=10 and `sweep_wrap` pulses. Two full periods are observed with no `done`.
- Overflow: N=8, f_start=500, f_stop=511, step=10, dwell=0. Sequence is 500, 510, then `done` (520 carries past 511).
- Abort during the 20 dwell in the single-shot case: next cycle `freq_out`=0 and `busy`=0, with no `done`. A new `start` then restarts from 10.
- Ignored start and mid-run config change: `start` re-pulsed and `cfg_f_stop` changed while `busy`. The sequence is unchanged.
- With `DDS_SWEEP_BIDIR_EN`: f_start=10, f_stop=30, step=10, dwell=0, loop=0. Sequence is 10, 20, 30, 20, 10, then `done`.
